// File: rtl/eespfal_switch_driver.sv
// eespfal_switch_driver
// Sequencer for the 4-lane EESPFAL dual-rail XOR switch macro.
// It steps the macro through discharge, setup, evaluate, hold and recovery
// phases, drives the dual-rail x/k operands, and synchronises and captures
// the macro's s/s_bar response. The captured s is checked against x ^ k and
// against the dual-rail encoding.
// All macro-facing drives are registered. They are decoded from the next
// state, so every drive changes on the same edge as the state it belongs to.

module eespfal_switch_driver #(
  parameter int BIT_SIZE  = 4,  // lanes; must match the switch macro
  parameter int DIS_CYC   = 4,  // 1..255
  parameter int SETUP_CYC = 2,  // 1..255
  parameter int EVAL_CYC  = 4,  // 1..255
  parameter int HOLD_CYC  = 4,  // 3..255, so the 2-flop synchroniser settles
  parameter int RECOV_CYC = 4   // 1..255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BIT_SIZE-1:0] x_in,
  input  logic [BIT_SIZE-1:0] k_in,
  output logic                busy,
  output logic                done,
  output logic [BIT_SIZE-1:0] result,
  output logic [BIT_SIZE-1:0] rail_err,
  output logic                mismatch,
  output logic [BIT_SIZE-1:0] clk_top,
  output logic [BIT_SIZE-1:0] dis_top,
  output logic                dis_phase_top,
  output logic [BIT_SIZE-1:0] x_top,
  output logic [BIT_SIZE-1:0] x_bar_top,
  output logic [BIT_SIZE-1:0] k_top,
  output logic [BIT_SIZE-1:0] k_bar_top,
  input  logic [BIT_SIZE-1:0] s_top,
  input  logic [BIT_SIZE-1:0] s_bar_top
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISCH,
    S_SETUP,
    S_EVAL,
    S_HOLD,
    S_RECOV,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // Latched operands for the operation in flight.
  logic [BIT_SIZE-1:0] x_op_q, k_op_q;

  // Synchroniser stages for the macro outputs, which are asynchronous to clk.
  logic [BIT_SIZE-1:0] s_meta_q, s_sync_q;
  logic [BIT_SIZE-1:0] sb_meta_q, sb_sync_q;

  // Decoded next-cycle drive values; they are registered below.
  logic                busy_d, done_d, dis_phase_d;
  logic [BIT_SIZE-1:0] clk_d, dis_d, x_d, x_bar_d, k_d, k_bar_d;
  logic                rails_on, clk_on;

  // Capture fires on the last HOLD cycle unless abort cancels the operation.
  logic capture_en;

  // Counter preload for a phase: the phase lasts preload+1 cycles.
  function automatic logic [7:0] entry_count(input state_t s);
    case (s)
      S_DISCH: entry_count = 8'(DIS_CYC - 1);
      S_SETUP: entry_count = 8'(SETUP_CYC - 1);
      S_EVAL:  entry_count = 8'(EVAL_CYC - 1);
      S_HOLD:  entry_count = 8'(HOLD_CYC - 1);
      S_RECOV: entry_count = 8'(RECOV_CYC - 1);
      default: entry_count = 8'd0;
    endcase
  endfunction

  // Next-state logic: each timed phase advances when its down-counter hits zero.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)          state_d = S_DISCH;
      S_DISCH: if (cnt_q == 8'd0)  state_d = S_SETUP;
      S_SETUP: if (cnt_q == 8'd0)  state_d = S_EVAL;
      S_EVAL:  if (cnt_q == 8'd0)  state_d = S_HOLD;
      S_HOLD:  if (cnt_q == 8'd0)  state_d = S_RECOV;
      S_RECOV: if (cnt_q == 8'd0)  state_d = S_DONE;
      S_DONE:                      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
    // Abort is honoured in every busy state. In IDLE a start always wins.
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Phase counter: preload on every state change, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = entry_count(state_d);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Drive decode for the upcoming cycle. A pair of rails is either null (both 0)
  // or complementary, so both rails of a pair are never high together.
  always_comb begin
    rails_on    = (state_d == S_SETUP) || (state_d == S_EVAL) || (state_d == S_HOLD);
    clk_on      = (state_d == S_EVAL)  || (state_d == S_HOLD);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    dis_phase_d = (state_d == S_DISCH);
    dis_d       = (state_d == S_DISCH) ? '1 : '0;
    clk_d       = clk_on ? '1 : '0;
    x_d         = rails_on ? x_op_q  : '0;
    x_bar_d     = rails_on ? ~x_op_q : '0;
    k_d         = rails_on ? k_op_q  : '0;
    k_bar_d     = rails_on ? ~k_op_q : '0;
    capture_en  = (state_q == S_HOLD) && (state_d == S_RECOV);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand latch: only a start accepted in IDLE loads new operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_op_q <= '0;
      k_op_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      x_op_q <= x_in;
      k_op_q <= k_in;
    end
  end

  // Registered macro drives and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      clk_top       <= '0;
      dis_top       <= '0;
      dis_phase_top <= 1'b0;
      x_top         <= '0;
      x_bar_top     <= '0;
      k_top         <= '0;
      k_bar_top     <= '0;
    end else begin
      busy          <= busy_d;
      done          <= done_d;
      clk_top       <= clk_d;
      dis_top       <= dis_d;
      dis_phase_top <= dis_phase_d;
      x_top         <= x_d;
      x_bar_top     <= x_bar_d;
      k_top         <= k_d;
      k_bar_top     <= k_bar_d;
    end
  end

  // Two-flop synchronisers for s and s_bar.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta_q  <= '0;
      s_sync_q  <= '0;
      sb_meta_q <= '0;
      sb_sync_q <= '0;
    end else begin
      s_meta_q  <= s_top;
      s_sync_q  <= s_meta_q;
      sb_meta_q <= s_bar_top;
      sb_sync_q <= sb_meta_q;
    end
  end

  // Result capture; the values hold until the next capture or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      rail_err <= '0;
      mismatch <= 1'b0;
    end else if (capture_en) begin
      result   <= s_sync_q;
      rail_err <= ~(s_sync_q ^ sb_sync_q);
      mismatch <= (s_sync_q != (x_op_q ^ k_op_q)) || (|(~(s_sync_q ^ sb_sync_q)));
    end
  end

endmodule

// File: tb/tb_eespfal_switch_driver.sv
// tb_eespfal_switch_driver
// The stimulus process runs operations and pushes the expected capture
// results into a scoreboard queue. A monitor process samples the DUT once per
// cycle. It checks the phase drives against a cycle-window model and pops the
// queue on every done pulse. A small behavioural model of the switch macro
// answers from the rails. It can flip bits of s or s_bar to inject faults.

module tb_eespfal_switch_driver;

  localparam int DIS = 4, SET = 2, EVA = 4, HLD = 4, REC = 4;
  localparam int SUM     = DIS + SET + EVA + HLD + REC;  // done shows at relative cycle SUM+1
  localparam int CAP_REL = DIS + SET + EVA + HLD;        // capture at the end of this relative cycle
  localparam int NEVER   = 32'h7fff_ffff;

  typedef struct {
    logic [3:0] res;
    logic [3:0] rail;
    logic       mm;
    int         done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] x_in = 4'h0, k_in = 4'h0;
  logic       busy, done, mismatch, dis_phase_top;
  logic [3:0] result, rail_err, clk_top, dis_top;
  logic [3:0] x_top, x_bar_top, k_top, k_bar_top;
  logic [3:0] s_top, s_bar_top;
  logic [3:0] s_flip = 4'h0, sb_flip = 4'h0;

  int   tot = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   op_c = -1000;
  int   cancel_cyc = NEVER;
  logic [3:0] op_x = 4'h0, op_k = 4'h0;
  logic [3:0] last_res = 4'h0, last_rail = 4'h0;
  logic       last_mm = 1'b0;

  eespfal_switch_driver #(
    .BIT_SIZE(4), .DIS_CYC(DIS), .SETUP_CYC(SET), .EVAL_CYC(EVA),
    .HOLD_CYC(HLD), .RECOV_CYC(REC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_in(x_in), .k_in(k_in),
    .busy(busy), .done(done), .result(result), .rail_err(rail_err),
    .mismatch(mismatch), .clk_top(clk_top), .dis_top(dis_top),
    .dis_phase_top(dis_phase_top), .x_top(x_top), .x_bar_top(x_bar_top),
    .k_top(k_top), .k_bar_top(k_bar_top), .s_top(s_top), .s_bar_top(s_bar_top)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: the XOR evaluates while CLK is high. Otherwise both outputs are null.
  always_comb begin
    s_top     = 4'h0;
    s_bar_top = 4'h0;
    if (clk_top == 4'hF) begin
      s_top     = (x_top ^ k_top) ^ s_flip;
      s_bar_top = (x_top ^ k_bar_top) ^ sb_flip;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tot++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Phase for a cycle numbered from 1 after the accepting edge:
  // 0 idle, 1 disch, 2 setup, 3 eval, 4 hold, 5 recov, 6 done.
  function automatic int phase_of(input int rel);
    if (rel < 1)                  return 0;
    if (rel <= DIS)               return 1;
    if (rel <= DIS + SET)         return 2;
    if (rel <= DIS + SET + EVA)   return 3;
    if (rel <= CAP_REL)           return 4;
    if (rel <= SUM)               return 5;
    if (rel == SUM + 1)           return 6;
    return 0;
  endfunction

  // Monitor: checks the phase drives every cycle and scores done pulses.
  initial begin
    exp_t e;
    int ph;
    logic on, ck;
    forever begin
      @(posedge clk);
      #1;
      ph = (rst_n && (cyc < cancel_cyc)) ? phase_of(cyc - op_c + 1) : 0;
      on = (ph == 2) || (ph == 3) || (ph == 4);
      ck = (ph == 3) || (ph == 4);
      check("busy",      64'(busy),          64'(ph != 0));
      check("dis_top",   64'(dis_top),       64'((ph == 1) ? 4'hF : 4'h0));
      check("dis_phase", 64'(dis_phase_top), 64'(ph == 1));
      check("clk_top",   64'(clk_top),       64'(ck ? 4'hF : 4'h0));
      check("x_top",     64'(x_top),         64'(on ? op_x : 4'h0));
      check("x_bar_top", 64'(x_bar_top),     64'(on ? 4'(~op_x) : 4'h0));
      check("k_top",     64'(k_top),         64'(on ? op_k : 4'h0));
      check("k_bar_top", 64'(k_bar_top),     64'(on ? 4'(~op_k) : 4'h0));
      check("x_rail_excl", 64'(x_top & x_bar_top), 64'(0));
      check("k_rail_excl", 64'(k_top & k_bar_top), 64'(0));
      check("done_phase", 64'(done),         64'(ph == 6));
      if ((exp_q.size() > 0) && (cyc >= exp_q[0].done_cyc)) begin
        e = exp_q.pop_front();
        check("done_pulse", 64'(done),     64'(1));
        check("result",     64'(result),   64'(e.res));
        check("rail_err",   64'(rail_err), 64'(e.rail));
        check("mismatch",   64'(mismatch), 64'(e.mm));
        last_res  = e.res;
        last_rail = e.rail;
        last_mm   = e.mm;
      end else begin
        check("stray_done", 64'(done), 64'(0));
      end
    end
  end

  // One operation, entered at a negedge with the DUT idle.
  // abort_rel / rst_rel: relative cycle in which abort / reset is applied (0 = none).
  // spur: start pulses while busy, one bit per relative cycle.
  task automatic run_op(input logic [3:0] x, input logic [3:0] k,
                        input logic [3:0] sf, input logic [3:0] bf,
                        input int abort_rel, input int rst_rel,
                        input logic [31:0] spur);
    exp_t e;
    int c;
    logic [3:0] se, sbe;
    x_in = x; k_in = k; s_flip = sf; sb_flip = bf; start = 1'b1;
    c = cyc + 1;
    se  = (x ^ k) ^ sf;
    sbe = 4'(~(x ^ k)) ^ bf;
    e.res      = se;
    e.rail     = ~(se ^ sbe);
    e.mm       = (se != (x ^ k)) || (e.rail != 4'h0);
    e.done_cyc = c + SUM;
    exp_q.push_back(e);
    op_c = c; op_x = x; op_k = k; cancel_cyc = NEVER;
    for (int rel = 1; rel <= SUM + 1; rel++) begin
      @(negedge clk);
      start = spur[rel];
      x_in  = 4'($urandom);
      k_in  = 4'($urandom);
      if (rel == abort_rel) begin
        abort = 1'b1;
        exp_q.delete(exp_q.size() - 1);
        cancel_cyc = c + rel;
        if (rel > CAP_REL) begin
          last_res = e.res; last_rail = e.rail; last_mm = e.mm;
        end
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_hold_result", 64'(result),   64'(last_res));
        check("abort_hold_rail",   64'(rail_err), 64'(last_rail));
        check("abort_hold_mm",     64'(mismatch), 64'(last_mm));
        return;
      end
      if (rel == rst_rel) begin
        rst_n = 1'b0;
        #1;
        check("async_reset_outs",
              64'({busy, done, result, rail_err, mismatch, clk_top, dis_top,
                   dis_phase_top, x_top, x_bar_top, k_top, k_bar_top}), 64'(0));
        exp_q.delete(exp_q.size() - 1);
        cancel_cyc = c + rel;
        last_res = 4'h0; last_rail = 4'h0; last_mm = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Stimulus: directed scenarios, then randomized operations.
  initial begin
    logic [3:0] rx, rk, rsf, rbf;
    int f, a, lim;
    logic [31:0] sp;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_capture", 64'({result, rail_err, mismatch, done}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'hA, 4'h6, 4'h0, 4'h0, 0, 0, 32'h0);                  // clean op
    run_op(4'hA, 4'h6, 4'h0, 4'hE, 0, 0, 32'h0);                  // s_bar reads 4'hD
    run_op(4'hA, 4'h6, 4'h0, 4'h0, 0, 0, (32'd1 << 3) | (32'd1 << 19)); // starts while busy / in DONE
    run_op(4'h5, 4'h3, 4'h0, 4'h0, 8, 0, 32'h0);                  // abort in EVAL
    run_op(4'hA, 4'h6, 4'h0, 4'h0, 0, 12, 32'h0);                 // reset in HOLD
    run_op(4'hA, 4'h6, 4'h0, 4'h0, 0, 0, 32'h0);                  // clean op after reset
    run_op(4'hF, 4'hF, 4'h2, 4'h0, 0, 0, 32'h0);                  // s corrupted

    for (int n = 0; n < 24; n++) begin
      rx  = 4'($urandom);
      rk  = 4'($urandom);
      f   = int'($urandom_range(0, 3));
      rsf = (f == 2) ? 4'($urandom) : 4'h0;
      rbf = (f == 3) ? 4'($urandom) : 4'h0;
      a   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, SUM)) : 0;
      lim = (a != 0) ? a : SUM + 1;
      sp  = ($urandom_range(0, 1) == 1) ? (32'd1 << $urandom_range(1, lim)) : 32'h0;
      run_op(rx, rk, rsf, rbf, a, 0, sp);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  // Watchdog so a stalled run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
